// File: rtl/game_pkg.sv
// Shared types for the game sequencer: FSM states, lane codes and small helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_LOGO_FADE = 3'd2,
        ST_PLAYER_IN = 3'd3,
        ST_PLAY      = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [1:0] LANE_L = 2'd0;
    localparam logic [1:0] LANE_C = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    // RNG lane code 3 is not a real lane and folds onto the centre.
    function automatic logic [1:0] lane_from_rng(input logic [1:0] r);
        return (r == 2'd3) ? LANE_C : r;
    endfunction

    function automatic logic [2:0] state_code(input state_t s);
        return 3'(s);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Stimulus and layer-control bundle between the game sequencer and its surroundings.
interface game_sequencer_if #(
    parameter int WIDTH     = 12,
    parameter int NUM_COINS = 3,
    parameter int RNG_WIDTH = 20
);
    logic                              vsync;
    logic                              btn_left;
    logic                              btn_right;
    logic [RNG_WIDTH-1:0]              random;
    logic [WIDTH-1:0]                  logo_voffset;
    logic [WIDTH-1:0]                  head_hoffset;
    logic [WIDTH-1:0]                  head_voffset;
    logic [NUM_COINS-1:0][WIDTH-1:0]   coin_loc;
    logic [NUM_COINS-1:0]              coin_active;
    logic [NUM_COINS-1:0][1:0]         coin_lane;
    logic [15:0]                       score;
    logic [3:0]                        misses;
    logic                              game_over;
    logic [2:0]                        state_o;

    modport master (
        input  vsync, btn_left, btn_right, random,
        output logo_voffset, head_hoffset, head_voffset, coin_loc, coin_active,
               coin_lane, score, misses, game_over, state_o
    );

    modport slave (
        output vsync, btn_left, btn_right, random,
        input  logo_voffset, head_hoffset, head_voffset, coin_loc, coin_active,
               coin_lane, score, misses, game_over, state_o
    );
endinterface

// File: rtl/sync_edge.sv
// 2-FF synchroniser with a previous-value flop updated only when en is high.
// rise is combinational: synchronised level high while the last enabled sample was low.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic rise
);
    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (en) prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
endmodule

// File: rtl/game_sequencer.sv
// Frame-driven Temple Run controller: intro sequence, three-lane play with coin slots, game over.
// All state advances once per synchronised vsync rise; outputs move on the 3rd clock seeing vsync high.
module game_sequencer
    import game_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int NUM_COINS   = 3,
    parameter int RNG_WIDTH   = 20,
    parameter int COUNTDOWN   = 5,
    parameter int LOGO_END    = 640,
    parameter int LOGO_STEP   = 30,
    parameter int HEAD_START  = 180,
    parameter int HEAD_END    = 50,
    parameter int HEAD_STEP   = 20,
    parameter int LANE_OFFSET = 100,
    parameter int COIN_START  = -50,
    parameter int COIN_END    = 120,
    parameter int SPAWN_GAP   = 8,
    parameter int MAX_MISSES  = 3
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    game_sequencer_if.master bus
);
    logic tick, left_rise, right_rise, press_l, press_r;

    sync_edge u_vsync (.clk(CLK100MHZ), .rst_n(CPU_RESETN), .en(1'b1), .din(bus.vsync),     .rise(tick));
    sync_edge u_left  (.clk(CLK100MHZ), .rst_n(CPU_RESETN), .en(tick), .din(bus.btn_left),  .rise(left_rise));
    sync_edge u_right (.clk(CLK100MHZ), .rst_n(CPU_RESETN), .en(tick), .din(bus.btn_right), .rise(right_rise));

    assign press_l = tick & left_rise;
    assign press_r = tick & right_rise;

    state_t                          state, nxt_state;
    logic [7:0]                      countdown, cooldown, nxt_cool;
    logic [WIDTH-1:0]                logo_voffset, head_voffset;
    logic [1:0]                      lane, nxt_lane;
    logic [NUM_COINS-1:0][WIDTH-1:0] coin_loc, nxt_loc;
    logic [NUM_COINS-1:0]            coin_active, nxt_act;
    logic [NUM_COINS-1:0][1:0]       coin_lane, nxt_clane;
    logic [15:0]                     score, nxt_score;
    logic [3:0]                      misses, nxt_misses;
    logic                            hit, miss, found, spawn_en;
    logic                            unused_rng;

    assign unused_rng = ^bus.random[RNG_WIDTH-1:3];

    // Play-phase update, computed entirely from start-of-tick values.
    always_comb begin
        nxt_loc   = coin_loc;
        nxt_act   = coin_active;
        nxt_clane = coin_lane;
        hit       = 1'b0;
        miss      = 1'b0;
        found     = 1'b0;
        spawn_en  = (cooldown == 8'd0) && bus.random[0];
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_active[i]) begin
                if (coin_loc[i] == WIDTH'(COIN_END)) begin
                    nxt_act[i] = 1'b0;
                    if (coin_lane[i] == lane) hit = 1'b1;
                    else                      miss = 1'b1;
                end else begin
                    nxt_loc[i] = coin_loc[i] + WIDTH'(1);
                end
            end else if (!found) begin
                found = 1'b1;
                if (spawn_en) begin
                    nxt_act[i]   = 1'b1;
                    nxt_loc[i]   = WIDTH'(COIN_START);
                    nxt_clane[i] = lane_from_rng(bus.random[2:1]);
                end
            end
        end
        if (spawn_en && found)      nxt_cool = 8'(SPAWN_GAP);
        else if (cooldown != 8'd0)  nxt_cool = cooldown - 8'd1;
        else                        nxt_cool = 8'd0;
        nxt_lane = lane;
        if (press_l && !press_r && lane != LANE_L) nxt_lane = lane - 2'd1;
        if (press_r && !press_l && lane != LANE_R) nxt_lane = lane + 2'd1;
        nxt_score  = (hit && score != 16'hFFFF) ? score + 16'd1 : score;
        nxt_misses = miss ? misses + 4'd1 : misses;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= ST_RESET;
        else             state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (tick) begin
            case (state)
                ST_RESET:     nxt_state = ST_COUNTDOWN;
                ST_COUNTDOWN: if (countdown == 8'd0) nxt_state = ST_LOGO_FADE;
                ST_LOGO_FADE: if (logo_voffset >= WIDTH'(LOGO_END)) nxt_state = ST_PLAYER_IN;
                ST_PLAYER_IN: if (head_voffset <= WIDTH'(HEAD_END)) nxt_state = ST_PLAY;
                ST_PLAY:      if (nxt_misses >= 4'(MAX_MISSES)) nxt_state = ST_GAME_OVER;
                ST_GAME_OVER: if (press_l || press_r) nxt_state = ST_RESET;
                default:      nxt_state = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            countdown    <= 8'(COUNTDOWN);
            cooldown     <= 8'd0;
            logo_voffset <= '0;
            head_voffset <= WIDTH'(HEAD_START);
            lane         <= LANE_C;
            coin_loc     <= {NUM_COINS{WIDTH'(COIN_START)}};
            coin_active  <= '0;
            coin_lane    <= {NUM_COINS{LANE_C}};
            score        <= '0;
            misses       <= '0;
        end else if (tick) begin
            case (state)
                ST_RESET: begin
                    countdown    <= 8'(COUNTDOWN);
                    cooldown     <= 8'd0;
                    logo_voffset <= '0;
                    head_voffset <= WIDTH'(HEAD_START);
                    lane         <= LANE_C;
                    coin_loc     <= {NUM_COINS{WIDTH'(COIN_START)}};
                    coin_active  <= '0;
                    coin_lane    <= {NUM_COINS{LANE_C}};
                    score        <= '0;
                    misses       <= '0;
                end
                ST_COUNTDOWN: if (countdown != 8'd0) countdown <= countdown - 8'd1;
                ST_LOGO_FADE: if (logo_voffset < WIDTH'(LOGO_END))
                                  logo_voffset <= logo_voffset + WIDTH'(LOGO_STEP);
                ST_PLAYER_IN: if (head_voffset > WIDTH'(HEAD_END))
                                  head_voffset <= head_voffset - WIDTH'(HEAD_STEP);
                ST_PLAY: begin
                    coin_loc    <= nxt_loc;
                    coin_active <= nxt_act;
                    coin_lane   <= nxt_clane;
                    cooldown    <= nxt_cool;
                    lane        <= nxt_lane;
                    score       <= nxt_score;
                    misses      <= nxt_misses;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.state_o   = state_code(state);
        bus.game_over = (state == ST_GAME_OVER);
        case (lane)
            LANE_L:  bus.head_hoffset = WIDTH'(-LANE_OFFSET);
            LANE_R:  bus.head_hoffset = WIDTH'(LANE_OFFSET);
            default: bus.head_hoffset = '0;
        endcase
    end

    assign bus.logo_voffset = logo_voffset;
    assign bus.head_voffset = head_voffset;
    assign bus.coin_loc     = coin_loc;
    assign bus.coin_active  = coin_active;
    assign bus.coin_lane    = coin_lane;
    assign bus.score        = score;
    assign bus.misses       = misses;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: intro timing, spawning, scoring, misses, game over and async reset.
module tb_game_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   t = 0;

    always #5 clk = ~clk;

    game_sequencer_if #(.WIDTH(12), .NUM_COINS(3), .RNG_WIDTH(20)) bus ();

    game_sequencer dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One vsync pulse: 4 clocks high, 4 low; the tick lands inside the high phase.
    task automatic frame();
        @(negedge clk) bus.vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.vsync = 1'b0;
        repeat (4) @(negedge clk);
        t++;
    endtask

    task automatic adv_to(input int target);
        while (t < target) frame();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.vsync     = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.random    = 20'h5;   // spawn bit set, lane code 2
        repeat (3) @(negedge clk);
        check("rst_state", bus.state_o, 3'd0);
        check("rst_logo", bus.logo_voffset, 12'd0);
        check("rst_head", bus.head_voffset, 12'd180);
        check("rst_hoff", bus.head_hoffset, 12'd0);
        check("rst_active", bus.coin_active, 3'b000);
        check("rst_loc0", bus.coin_loc[0], 12'hFCE);
        check("rst_lane2", bus.coin_lane[2], 2'd1);
        check("rst_score", bus.score, 16'd0);
        check("rst_gover", bus.game_over, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        adv_to(1);   check("st_t1", bus.state_o, 3'd1);
        adv_to(6);   check("st_t6", bus.state_o, 3'd1);
        adv_to(7);   check("st_t7", bus.state_o, 3'd2);
        adv_to(29);  check("st_t29", bus.state_o, 3'd2);
        adv_to(30);  check("st_t30", bus.state_o, 3'd3);
                     check("logo_end", bus.logo_voffset, 12'd660);
        adv_to(37);  check("st_t37", bus.state_o, 3'd3);
        adv_to(38);  check("st_t38", bus.state_o, 3'd4);
                     check("head_end", bus.head_voffset, 12'd40);

        adv_to(39);  check("spawn0_act", bus.coin_active, 3'b001);
                     check("spawn0_loc", bus.coin_loc[0], 12'hFCE);
                     check("spawn0_lane", bus.coin_lane[0], 2'd2);
        adv_to(47);  check("gap_act", bus.coin_active, 3'b001);
        adv_to(48);  check("spawn1_act", bus.coin_active, 3'b011);
                     check("spawn1_loc", bus.coin_loc[1], 12'hFCE);
                     check("adv_loc0", bus.coin_loc[0], 12'hFD7);

        adv_to(99);  bus.btn_right = 1'b1;
        adv_to(100); check("right_move", bus.head_hoffset, 12'd100);
        adv_to(119); check("right_hold", bus.head_hoffset, 12'd100);
        bus.btn_right = 1'b0;
        adv_to(129); bus.btn_left = 1'b1; bus.btn_right = 1'b1;
        adv_to(130); check("both_press", bus.head_hoffset, 12'd100);
        bus.btn_left = 1'b0; bus.btn_right = 1'b0;

        adv_to(209); check("loc0_end", bus.coin_loc[0], 12'd120);
                     check("slot0_live", bus.coin_active, 3'b111);
        adv_to(210); check("resolve_act", bus.coin_active, 3'b110);
                     check("score_hit", bus.score, 16'd1);
                     check("miss_none", bus.misses, 4'd0);

        bus.btn_left = 1'b1; adv_to(211);
        check("left_c", bus.head_hoffset, 12'd0);
        check("respawn0", bus.coin_active, 3'b111);
        bus.btn_left = 1'b0; adv_to(212);
        bus.btn_left = 1'b1; adv_to(213);
        check("left_l", bus.head_hoffset, 12'hF9C);
        bus.btn_left = 1'b0; adv_to(214);
        bus.btn_left = 1'b1; adv_to(215);
        check("left_sat", bus.head_hoffset, 12'hF9C);
        bus.btn_left = 1'b0;

        adv_to(218); check("miss_pre", bus.misses, 4'd0);
        adv_to(219); check("miss1", bus.misses, 4'd1);
                     check("score_keep", bus.score, 16'd1);
        adv_to(228); check("miss2", bus.misses, 4'd2);
        adv_to(381); check("st_play381", bus.state_o, 3'd4);
        adv_to(382); check("miss3", bus.misses, 4'd3);
                     check("go_state", bus.state_o, 3'd5);
                     check("go_flag", bus.game_over, 1'b1);
                     check("go_loc1", bus.coin_loc[1], 12'd112);
        adv_to(383); check("go_frozen", bus.coin_loc[1], 12'd112);
                     check("go_hold", bus.state_o, 3'd5);
        bus.btn_left = 1'b1; adv_to(384);
        check("go_exit", bus.state_o, 3'd0);
        check("go_clear", bus.game_over, 1'b0);
        bus.btn_left = 1'b0; adv_to(385);
        check("restart_cd", bus.state_o, 3'd1);
        check("restart_score", bus.score, 16'd0);
        check("restart_miss", bus.misses, 4'd0);

        adv_to(422); check("replay", bus.state_o, 3'd4);
        adv_to(423); check("replay_spawn", bus.coin_active, 3'b001);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", bus.state_o, 3'd0);
        check("arst_active", bus.coin_active, 3'b000);
        check("arst_head", bus.head_voffset, 12'd180);
        check("arst_logo", bus.logo_voffset, 12'd0);
        check("arst_loc0", bus.coin_loc[0], 12'hFCE);
        check("arst_score", bus.score, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_tick", bus.state_o, 3'd0);
        frame();
        check("post_rst_tick", bus.state_o, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
